wb4_sync_fifo_1_to_n: RTL

WB4_SYNC_FIFO_1_TO_N -- requirements
Module: wb4_sync_fifo_1_to_n

---
 rtl/wb4_sync_fifo_1_to_n.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/wb4_sync_fifo_1_to_n.sv
// ---------------------------------------------------------------------------------------------
// wb4_sync_fifo_1_to_n
//
// Single-clock FIFO that takes wide words on a Wishbone B4 style slave write port and returns
// them as R = (P_DATA_I_MSB+1)/(P_DATA_O_MSB+1) narrow beats on a Wishbone B4 style slave read
// port, least-significant slice first. Occupancy is counted in wide words, including a word
// that has been partly read out.
//
// Parameters
//   P_DATA_I_MSB  write data width minus one
//   P_DATA_O_MSB  read data width minus one (ratio R must be a power of two, 1..16)
//   P_DEPTH       storage entries in wide words (power of two, >= 2)
//   P_USE_BRAM    1 = block-RAM-friendly synchronous read, 0 = LUT storage (same timing)
//   P_AFULL_LVL   o_almost_full  when o_level >= this
//   P_AEMPTY_LVL  o_almost_empty when o_level <= this
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wb4_in_*            write port: scyc/sstb in, sdata in, sack out, stall = full,
//                         stgd = empty
//   i_wb4_out_*           read port: scyc/sstb in, sdata out, sack out, stall = empty,
//                         stgd = full
//   i_flush               synchronous discard of all contents
//   o_level               occupied wide words
//   o_almost_full/empty   threshold flags, same timing as o_level
// ---------------------------------------------------------------------------------------------
module wb4_sync_fifo_1_to_n #(
   parameter int unsigned P_DATA_I_MSB = 31,
   parameter int unsigned P_DATA_O_MSB = 7,
   parameter int unsigned P_DEPTH      = 128,
   parameter int unsigned P_USE_BRAM   = 1,
   parameter int unsigned P_AFULL_LVL  = P_DEPTH - 2,
   parameter int unsigned P_AEMPTY_LVL = 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   // write side
   input  logic                      i_wb4_in_scyc,
   input  logic                      i_wb4_in_sstb,
   output logic                      o_wb4_in_sack,
   input  logic [P_DATA_I_MSB:0]     i_wb4_in_sdata,
   output logic                      o_wb4_in_stgd,
   output logic                      o_wb4_in_sstall,
   // read side
   input  logic                      i_wb4_out_scyc,
   input  logic                      i_wb4_out_sstb,
   output logic                      o_wb4_out_sack,
   output logic [P_DATA_O_MSB:0]     o_wb4_out_sdata,
   output logic                      o_wb4_out_stgd,
   output logic                      o_wb4_out_sstall,
   // control / status
   input  logic                      i_flush,
   output logic [$clog2(P_DEPTH):0]  o_level,
   output logic                      o_almost_full,
   output logic                      o_almost_empty
);

   localparam int unsigned DW = P_DATA_I_MSB + 1;
   localparam int unsigned OW = P_DATA_O_MSB + 1;
   localparam int unsigned R  = DW / OW;
   localparam int unsigned SW = (R > 1) ? $clog2(R) : 1;
   localparam int unsigned AW = $clog2(P_DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [SW-1:0] slice_q, slice_d;
   logic [LW-1:0] level_q, level_d;
   logic          in_ack_q, out_ack_q;
   logic [OW-1:0] rdata_q, rdata_d;

   logic          full, empty;
   logic          wr_acc, rd_acc, pop;
   logic [DW-1:0] rd_word;

   // ------------------------------------------------------------------------------------------
   // Handshake decode. Full/empty come only from the registered level, so a pop never frees a
   // slot for a write in the same cycle and a write never feeds a read in the same cycle.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      full   = (level_q == LW'(P_DEPTH));
      empty  = (level_q == '0);
      wr_acc = i_wb4_in_scyc & i_wb4_in_sstb & ~full & ~i_flush & ~i_rst;
      rd_acc = i_wb4_out_scyc & i_wb4_out_sstb & ~empty & ~i_flush & ~i_rst;
      // the last slice of the head word retires it
      pop    = rd_acc & (slice_q == SW'(R - 1));
   end

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      slice_d  = slice_q;
      level_d  = level_q;
      rdata_d  = rdata_q;

      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         slice_d  = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (rd_acc) begin
            rdata_d = rd_word[slice_q*OW +: OW];
            if (pop) begin
               slice_d  = '0;
               rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
               slice_d = slice_q + SW'(1);
            end
         end
         case ({wr_acc, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // ------------------------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         slice_q   <= '0;
         level_q   <= '0;
         in_ack_q  <= 1'b0;
         out_ack_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         slice_q   <= slice_d;
         level_q   <= level_d;
         in_ack_q  <= wr_acc;
         out_ack_q <= rd_acc;
         rdata_q   <= rdata_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Storage. Contents are never reset; occupancy alone says what is valid.
   // ------------------------------------------------------------------------------------------
   if (P_USE_BRAM != 0) begin : g_bram
      (* ram_style = "block" *) logic [DW-1:0] mem [P_DEPTH];
      logic [DW-1:0] word_q;

      // Synchronous read of the next head word so the RAM output register can be used. When
      // the head entry is being written this cycle (FIFO was empty), take the write data
      // directly instead of the stale RAM word.
      always_ff @(posedge i_clk) begin
         if (wr_acc) begin
            mem[wr_ptr_q] <= i_wb4_in_sdata;
         end
         if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
            word_q <= i_wb4_in_sdata;
         end else begin
            word_q <= mem[rd_ptr_d];
         end
      end

      assign rd_word = word_q;
   end else begin : g_lut
      logic [DW-1:0] mem [P_DEPTH];

      always_ff @(posedge i_clk) begin
         if (wr_acc) begin
            mem[wr_ptr_q] <= i_wb4_in_sdata;
         end
      end

      assign rd_word = mem[rd_ptr_q];
   end

   // ------------------------------------------------------------------------------------------
   // Outputs, all straight from registers
   // ------------------------------------------------------------------------------------------
   assign o_wb4_in_sack    = in_ack_q;
   assign o_wb4_out_sack   = out_ack_q;
   assign o_wb4_out_sdata  = rdata_q;
   assign o_wb4_in_sstall  = full;
   assign o_wb4_out_stgd   = full;
   assign o_wb4_in_stgd    = empty;
   assign o_wb4_out_sstall = empty;
   assign o_level          = level_q;
   assign o_almost_full    = (32'(level_q) >= P_AFULL_LVL);
   assign o_almost_empty   = (32'(level_q) <= P_AEMPTY_LVL);

endmodule
